// File: rtl/bsr_pkg.sv
// Shared mode encodings for the pipelined barrel shifter.
package bsr_pkg;

   localparam int BSR_MODE_W = 3;

   typedef logic [BSR_MODE_W-1:0] bsr_mode_t;

   localparam bsr_mode_t BSR_LSL = 3'b000;
   localparam bsr_mode_t BSR_LSR = 3'b001;
   localparam bsr_mode_t BSR_ASR = 3'b010;
   localparam bsr_mode_t BSR_ROL = 3'b011;
   localparam bsr_mode_t BSR_ROR = 3'b100;

endpackage

// File: rtl/bsr_pipe_if.sv
// Operand-in / result-out handshake bundle for bsr_pipe.
interface bsr_pipe_if
   import bsr_pkg::*;
#(
   parameter int WIDTH = 16
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic [SHW-1:0]   shiftcnt;
   bsr_mode_t        mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             carry;
   logic             zero;

   modport master (
      output in_valid, din, shiftcnt, mode, out_ready,
      input  in_ready, out_valid, dout, carry, zero
   );

   modport slave (
      input  in_valid, din, shiftcnt, mode, out_ready,
      output in_ready, out_valid, dout, carry, zero
   );

endinterface

// File: rtl/bsr_stage.sv
// One pipeline stage: conditional shift/rotate by AMT, selected by count bit log2(AMT).
module bsr_stage
   import bsr_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     up_valid,
   input  logic [WIDTH-1:0]         up_data,
   input  logic [$clog2(WIDTH)-1:0] up_cnt,
   input  bsr_mode_t                up_mode,
   input  logic                     up_carry,
   input  logic                     up_fill,
   output logic                     dn_valid,
   output logic [WIDTH-1:0]         dn_data,
   output logic [$clog2(WIDTH)-1:0] dn_cnt,
   output bsr_mode_t                dn_mode,
   output logic                     dn_carry,
   output logic                     dn_fill,
   output logic                     dn_zero
);
   localparam int K = $clog2(AMT);
   localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> AMT);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] nxt_data;
   logic             shifted_out;
   logic             moves;
   logic             nxt_carry;

   // ASR fills from the original sign bit, carried alongside the word
   always_comb begin
      shifted     = up_data;
      shifted_out = 1'b0;
      moves       = 1'b1;
      case (up_mode)
         BSR_LSL: begin
            shifted     = up_data << AMT;
            shifted_out = up_data[WIDTH-AMT];
         end
         BSR_LSR: begin
            shifted     = up_data >> AMT;
            shifted_out = up_data[AMT-1];
         end
         BSR_ASR: begin
            shifted     = (up_data >> AMT) | (up_fill ? HI_MASK : '0);
            shifted_out = up_data[AMT-1];
         end
         BSR_ROL: begin
            shifted     = (up_data << AMT) | (up_data >> (WIDTH-AMT));
            shifted_out = up_data[WIDTH-AMT];
         end
         BSR_ROR: begin
            shifted     = (up_data >> AMT) | (up_data << (WIDTH-AMT));
            shifted_out = up_data[AMT-1];
         end
         default: moves = 1'b0;
      endcase

      nxt_data  = up_data;
      nxt_carry = up_carry;
      if (up_cnt[K] && moves) begin
         nxt_data  = shifted;
         nxt_carry = shifted_out;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
         dn_cnt   <= '0;
         dn_mode  <= BSR_LSL;
         dn_carry <= 1'b0;
         dn_fill  <= 1'b0;
         dn_zero  <= 1'b0;
      end else if (en) begin
         dn_valid <= up_valid;
         dn_data  <= nxt_data;
         dn_cnt   <= up_cnt;
         dn_mode  <= up_mode;
         dn_carry <= nxt_carry;
         dn_fill  <= up_fill;
         dn_zero  <= (nxt_data == '0);
      end
   end

endmodule

// File: rtl/bsr_pipe.sv
// Pipelined barrel shifter: SHW stages, shift/rotate with carry and zero flags.
module bsr_pipe
   import bsr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic       clk,
   input logic       rst_n,
   bsr_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   logic                 advance;
   logic [SHW:0]         valid;
   logic [SHW:0]         carry;
   logic [SHW:0]         fill;
   logic [WIDTH-1:0]     data [SHW+1];
   logic [SHW-1:0]       cnt  [SHW+1];
   bsr_mode_t            mode [SHW+1];
   logic [SHW-1:0]       stage_zero;
   logic                 unused_tail;

   // Whole pipe moves as one; a full, unconsumed output freezes every stage
   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   assign valid[0] = bus.in_valid;
   assign data[0]  = bus.din;
   assign cnt[0]   = bus.shiftcnt;
   assign mode[0]  = bus.mode;
   assign carry[0] = 1'b0;
   assign fill[0]  = bus.din[WIDTH-1];

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      bsr_stage #(
         .WIDTH (WIDTH),
         .AMT   (1 << k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (advance),
         .up_valid (valid[k]),
         .up_data  (data[k]),
         .up_cnt   (cnt[k]),
         .up_mode  (mode[k]),
         .up_carry (carry[k]),
         .up_fill  (fill[k]),
         .dn_valid (valid[k+1]),
         .dn_data  (data[k+1]),
         .dn_cnt   (cnt[k+1]),
         .dn_mode  (mode[k+1]),
         .dn_carry (carry[k+1]),
         .dn_fill  (fill[k+1]),
         .dn_zero  (stage_zero[k])
      );
   end

   assign bus.out_valid = valid[SHW];
   assign bus.dout      = data[SHW];
   assign bus.carry     = carry[SHW];
   assign bus.zero      = stage_zero[SHW-1];

   assign unused_tail = ^{cnt[SHW], mode[SHW], fill[SHW], stage_zero[SHW-2:0]};

endmodule

// File: tb/tb_bsr_pipe.sv
// Directed bench for bsr_pipe (WIDTH=16): single ops, stall/stream, mid-stream reset.
module tb_bsr_pipe;
   import bsr_pkg::*;

   localparam int WIDTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bsr_pipe_if #(.WIDTH(WIDTH)) bus ();

   bsr_pipe #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] d, input int unsigned n);
      logic [15:0] r;
      r = d;
      for (int unsigned j = 0; j < n; j++) r = {r[14:0], r[15]};
      return r;
   endfunction

   task automatic run_op(input string tag, input bsr_mode_t m, input logic [15:0] d,
                         input logic [3:0] c, input logic [15:0] ed, input logic ec,
                         input logic ez);
      int unsigned cyc;
      check({tag, "_in_ready"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.din      = d;
      bus.shiftcnt = c;
      bus.mode     = m;
      tick();
      bus.in_valid = 1'b0;
      bus.din      = ~d;
      bus.shiftcnt = ~c;
      bus.mode     = BSR_LSR;
      cyc = 1;
      while (!bus.out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, 4);
      check({tag, "_dout"}, bus.dout, ed);
      check({tag, "_carry"}, bus.carry, ec);
      check({tag, "_zero"}, bus.zero, ez);
      tick();
      check({tag, "_drained"}, bus.out_valid, 0);
   endtask

   logic [15:0] sdin [8];
   int unsigned idx_in;
   int unsigned idx_out;
   int unsigned extra;
   logic        stall_checked;

   initial begin
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.shiftcnt  = '0;
      bus.mode      = BSR_LSL;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      tick();
      tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_dout", bus.dout, 0);
      check("rst_carry", bus.carry, 0);
      check("rst_zero", bus.zero, 0);
      check("rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;
      tick();

      run_op("lsl_8001_1",  BSR_LSL, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0);
      run_op("asr_f000_15", BSR_ASR, 16'hF000, 4'd15, 16'hFFFF, 1'b1, 1'b0);
      run_op("lsr_f000_15", BSR_LSR, 16'hF000, 4'd15, 16'h0001, 1'b1, 1'b0);
      run_op("ror_0001_1",  BSR_ROR, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0);
      run_op("rol_1234_4",  BSR_ROL, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b0);
      run_op("lsl_00ff_8",  BSR_LSL, 16'h00FF, 4'd8,  16'hFF00, 1'b0, 1'b0);
      run_op("lsl_00ff_9",  BSR_LSL, 16'h00FF, 4'd9,  16'hFE00, 1'b1, 1'b0);
      run_op("lsr_0001_1",  BSR_LSR, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1);
      run_op("lsl_cnt0",    BSR_LSL, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0);
      run_op("asr_pos_3",   BSR_ASR, 16'h7000, 4'd3,  16'h0E00, 1'b0, 1'b0);
      run_op("rsv_111",     3'b111,  16'hA5C3, 4'd5,  16'hA5C3, 1'b0, 1'b0);

      // Stream 8 ROL words; output stalled for cycles 6..13
      for (int unsigned i = 0; i < 8; i++) sdin[i] = 16'(i * 16'h1357 + 16'h0101);
      idx_in        = 0;
      idx_out       = 0;
      stall_checked = 1'b0;
      for (int unsigned cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
         @(posedge clk);
         #1;
         bus.out_ready = !(cyc >= 6 && cyc < 14);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("stream_dout_%0d", idx_out), bus.dout, rotl(sdin[idx_out], idx_out));
            check($sformatf("stream_carry_%0d", idx_out), bus.carry,
                  (idx_out == 0) ? 1'b0 : rotl(sdin[idx_out], idx_out) & 16'h1);
            idx_out++;
         end
         if (bus.out_valid && !bus.out_ready && !stall_checked) begin
            check("stall_in_ready", bus.in_ready, 0);
            stall_checked = 1'b1;
         end
         if (idx_in < 8) begin
            bus.in_valid = 1'b1;
            if (bus.in_ready) begin
               bus.din      = sdin[idx_in];
               bus.mode     = BSR_ROL;
               bus.shiftcnt = 4'(idx_in);
               idx_in++;
            end else begin
               bus.din      = 16'hDEAD;
               bus.mode     = BSR_LSR;
               bus.shiftcnt = 4'hF;
            end
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("stream_count", idx_out, 8);
      check("stall_seen", stall_checked, 1);
      extra = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid) extra++;
      end
      check("stream_no_dup", extra, 0);

      // Three words in flight, then reset before any can emerge
      for (int unsigned i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.din      = 16'h0F0F + 16'(i);
         bus.mode     = BSR_LSL;
         bus.shiftcnt = 4'd2;
         tick();
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      extra = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) extra++;
      end
      check("midrst_flushed", extra, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
